// File: rtl/modbus_pkg.sv
// Shared definitions for the Modbus RTU frame receiver: FSM states, CRC-16
// constants and frame-level limits.
package modbus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV,
        ST_CHECK,
        ST_HOLD,
        ST_DISCARD
    } state_t;

    localparam logic [15:0] CRC_INIT      = 16'hFFFF;
    localparam logic [15:0] CRC_POLY      = 16'hA001;
    localparam int          MIN_FRAME_LEN = 4;
    localparam logic [7:0]  BCAST_ADDR    = 8'h00;

endpackage

// File: rtl/modbus_crc16_byte.sv
// One-byte update of the Modbus CRC-16 (reflected polynomial 0xA001), purely
// combinational so a whole byte is folded in per clock.
module modbus_crc16_byte
    import modbus_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data,
    output logic [15:0] crc_out
);

    logic [15:0] c;

    always_comb begin
        c = crc_in ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/modbus_rtu_frame_rx.sv
// Modbus RTU frame receiver: pops bytes from a UART controller, delimits frames
// by inter-frame silence, checks length/CRC/address and holds accepted frames.
module modbus_rtu_frame_rx
    import modbus_pkg::*;
#(
    parameter int         MAX_LEN          = 32,
    parameter int         CLKS_PER_BIT     = 434,
    parameter int         T35_CLKS         = 39 * CLKS_PER_BIT,
    parameter logic [7:0] SLAVE_ADDR       = 8'h01,
    parameter int         ACCEPT_BROADCAST = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [7:0]                   i_rx_data,
    input  logic                         i_rx_ready,
    output logic                         o_rx_rden,
    output logic                         o_frame_valid,
    output logic [$clog2(MAX_LEN+1)-1:0] o_frame_len,
    output logic                         o_frame_bcast,
    input  logic [$clog2(MAX_LEN)-1:0]   i_rd_addr,
    output logic [7:0]                   o_rd_data,
    input  logic                         i_frame_ack,
    output logic                         o_err_crc,
    output logic                         o_err_short,
    output logic                         o_err_overflow,
    output logic                         o_err_busy
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int IDX_W = $clog2(MAX_LEN);
    localparam int SIL_W = $clog2(T35_CLKS + 1);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_FRAME_LEN);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [SIL_W-1:0] SIL_MAX = SIL_W'(T35_CLKS);
    localparam logic [SIL_W-1:0] SIL_END = SIL_W'(T35_CLKS - 1);

    state_t            state;
    logic [LEN_W-1:0]  len;
    logic [15:0]       crc;
    logic [15:0]       crc_next;
    logic [15:0]       crc_seed;
    logic [SIL_W-1:0]  sil;
    logic              pop;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic              addr_ok;
    logic              bcast_hit;
    logic [7:0]        mem [MAX_LEN];

    // The strobe cycle is also the capture cycle: the controller presents the
    // byte while it waits for the pop.
    assign pop = o_rx_rden;

    assign crc_seed = (state == ST_IDLE) ? CRC_INIT : crc;

    modbus_crc16_byte u_crc (
        .crc_in  (crc_seed),
        .data    (i_rx_data),
        .crc_out (crc_next)
    );

    assign wr_en  = pop && ((state == ST_IDLE) || ((state == ST_RECV) && (len != LEN_MAX)));
    assign wr_idx = (state == ST_IDLE) ? '0 : len[IDX_W-1:0];

    assign bcast_hit = (mem[0] == BCAST_ADDR);
    assign addr_ok   = (mem[0] == SLAVE_ADDR) || ((ACCEPT_BROADCAST != 0) && bcast_hit);

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_idx] <= i_rx_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rd_data <= 8'h00;
        end else begin
            o_rd_data <= mem[i_rd_addr];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= ST_IDLE;
            o_rx_rden      <= 1'b0;
            len            <= '0;
            crc            <= CRC_INIT;
            sil            <= '0;
            o_frame_valid  <= 1'b0;
            o_frame_len    <= '0;
            o_frame_bcast  <= 1'b0;
            o_err_crc      <= 1'b0;
            o_err_short    <= 1'b0;
            o_err_overflow <= 1'b0;
            o_err_busy     <= 1'b0;
        end else begin
            o_rx_rden      <= i_rx_ready && !o_rx_rden;
            o_err_crc      <= 1'b0;
            o_err_short    <= 1'b0;
            o_err_overflow <= 1'b0;
            o_err_busy     <= 1'b0;

            if (pop) begin
                sil <= '0;
            end else if (sil != SIL_MAX) begin
                sil <= sil + 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        len   <= LEN_ONE;
                        crc   <= crc_next;
                        state <= ST_RECV;
                    end
                end

                // A pop wins over silence expiry, so a late byte still joins the frame.
                ST_RECV: begin
                    if (pop) begin
                        if (len == LEN_MAX) begin
                            o_err_overflow <= 1'b1;
                            state          <= ST_DISCARD;
                        end else begin
                            len <= len + 1'b1;
                            crc <= crc_next;
                        end
                    end else if (sil >= SIL_END) begin
                        state <= ST_CHECK;
                    end
                end

                ST_CHECK: begin
                    if (len < LEN_MIN) begin
                        o_err_short <= 1'b1;
                        state       <= ST_IDLE;
                    end else if (crc != 16'h0000) begin
                        o_err_crc <= 1'b1;
                        state     <= ST_IDLE;
                    end else if (!addr_ok) begin
                        state <= ST_IDLE;
                    end else begin
                        o_frame_valid <= 1'b1;
                        o_frame_len   <= len;
                        o_frame_bcast <= bcast_hit;
                        state         <= ST_HOLD;
                    end
                end

                // Bytes arriving now belong to a frame we cannot store; if the line
                // is still busy at release, skip the rest of that frame.
                ST_HOLD: begin
                    if (pop) begin
                        o_err_busy <= 1'b1;
                    end
                    if (i_frame_ack) begin
                        o_frame_valid <= 1'b0;
                        o_frame_len   <= '0;
                        o_frame_bcast <= 1'b0;
                        state         <= (pop || (sil != SIL_MAX)) ? ST_DISCARD : ST_IDLE;
                    end
                end

                ST_DISCARD: begin
                    if (!pop && (sil >= SIL_END)) begin
                        state <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_modbus_rtu_frame_rx.sv
// Directed bench for modbus_rtu_frame_rx with a small UART-controller model.
module tb_modbus_rtu_frame_rx;

    localparam int MAX_LEN = 16;
    localparam int T35     = 40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_ready = 1'b0;
    logic       rx_rden;
    logic       frame_valid;
    logic [4:0] frame_len;
    logic       frame_bcast;
    logic [3:0] rd_addr = 4'd0;
    logic [7:0] rd_data;
    logic       frame_ack = 1'b0;
    logic       err_crc, err_short, err_overflow, err_busy;

    int total = 0;
    int bad   = 0;
    int n_crc = 0, n_short = 0, n_ovf = 0, n_busy = 0;

    logic [7:0]  fr [$];
    logic [7:0]  fr_a [$];
    logic [15:0] c;
    bit          got;
    int          b_crc, b_short, b_ovf, b_busy;

    modbus_rtu_frame_rx #(
        .MAX_LEN          (MAX_LEN),
        .CLKS_PER_BIT     (4),
        .T35_CLKS         (T35),
        .SLAVE_ADDR       (8'h01),
        .ACCEPT_BROADCAST (1)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_rx_data      (rx_data),
        .i_rx_ready     (rx_ready),
        .o_rx_rden      (rx_rden),
        .o_frame_valid  (frame_valid),
        .o_frame_len    (frame_len),
        .o_frame_bcast  (frame_bcast),
        .i_rd_addr      (rd_addr),
        .o_rd_data      (rd_data),
        .i_frame_ack    (frame_ack),
        .o_err_crc      (err_crc),
        .o_err_short    (err_short),
        .o_err_overflow (err_overflow),
        .o_err_busy     (err_busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (err_crc)      n_crc++;
        if (err_short)    n_short++;
        if (err_overflow) n_ovf++;
        if (err_busy)     n_busy++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] crc_q(input logic [7:0] q [$]);
        logic [15:0] r = 16'hFFFF;
        foreach (q[i]) begin
            r = r ^ {8'h00, q[i]};
            for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        end
        return r;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int t;
        rx_data  = b;
        rx_ready = 1'b1;
        t = 0;
        while (rx_rden !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) check("pop_timeout", 32'(t), 32'd0);
        @(posedge clk);
        #1 rx_ready = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] q [$]);
        foreach (q[i]) send_byte(q[i]);
    endtask

    task automatic wait_valid(input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (frame_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic read_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        check(tag, 32'(rd_data), 32'(exp));
    endtask

    task automatic ack_frame();
        @(negedge clk);
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        check("ack_clears_valid", 32'(frame_valid), 32'd0);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        fr_a = '{8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h00, 8'h01, 8'h67, 8'h90};

        // Reset values
        idle_cycles(3);
        check("rst_rden",  32'(rx_rden),      32'd0);
        check("rst_valid", 32'(frame_valid),  32'd0);
        check("rst_len",   32'(frame_len),    32'd0);
        check("rst_bcast", 32'(frame_bcast),  32'd0);
        check("rst_rdata", 32'(rd_data),      32'd0);
        check("rst_errs",  32'({err_crc, err_short, err_overflow, err_busy}), 32'd0);
        rst_n = 1'b1;
        idle_cycles(3);

        // Good frame addressed to us
        send_frame(fr_a);
        wait_valid(100, got);
        check("a_valid", 32'(got), 32'd1);
        check("a_len",   32'(frame_len),   32'd11);
        check("a_bcast", 32'(frame_bcast), 32'd0);
        read_chk("a_rd0",  4'd0,  8'h01);
        read_chk("a_rd10", 4'd10, 8'h90);
        check("a_no_err", 32'(n_crc + n_short + n_ovf + n_busy), 32'd0);

        // Traffic while holding: every byte is busy, held frame untouched
        b_busy = n_busy;
        fr = '{8'h01, 8'h03, 8'h00, 8'h80, 8'h00, 8'h04, 8'h45, 8'hE1};
        send_frame(fr);
        idle_cycles(2);
        check("busy_count", 32'(n_busy - b_busy), 32'd8);
        check("busy_valid", 32'(frame_valid),     32'd1);
        check("busy_len",   32'(frame_len),       32'd11);
        read_chk("busy_rd1",  4'd1,  8'h10);
        read_chk("busy_rd10", 4'd10, 8'h90);
        ack_frame();
        idle_cycles(T35 + 10);

        // Corrupted CRC
        b_crc = n_crc;
        fr = fr_a;
        fr[10] = 8'h91;
        send_frame(fr);
        wait_valid(100, got);
        check("crc_no_valid", 32'(got), 32'd0);
        check("crc_pulse",    32'(n_crc - b_crc), 32'd1);

        // Valid CRC, foreign address: silent drop
        b_crc = n_crc;
        b_short = n_short;
        fr = '{8'h02, 8'h03, 8'h00, 8'h80, 8'h00, 8'h04};
        c = crc_q(fr);
        fr.push_back(c[7:0]);
        fr.push_back(c[15:8]);
        send_frame(fr);
        wait_valid(100, got);
        check("addr_no_valid", 32'(got), 32'd0);
        check("addr_no_err",   32'((n_crc - b_crc) + (n_short - b_short)), 32'd0);

        // Broadcast frame
        fr[0] = 8'h00;
        fr.delete(7);
        fr.delete(6);
        c = crc_q(fr);
        fr.push_back(c[7:0]);
        fr.push_back(c[15:8]);
        send_frame(fr);
        wait_valid(100, got);
        check("bc_valid", 32'(got), 32'd1);
        check("bc_bcast", 32'(frame_bcast), 32'd1);
        check("bc_len",   32'(frame_len),   32'd8);
        idle_cycles(T35 + 5);
        ack_frame();
        idle_cycles(3);

        // Short frame
        b_short = n_short;
        fr = '{8'h01, 8'h03, 8'h00};
        send_frame(fr);
        wait_valid(100, got);
        check("short_no_valid", 32'(got), 32'd0);
        check("short_pulse",    32'(n_short - b_short), 32'd1);

        // Overflow: MAX_LEN+1 bytes back to back
        b_ovf = n_ovf;
        b_crc = n_crc;
        b_short = n_short;
        fr.delete();
        for (int i = 0; i <= MAX_LEN; i++) fr.push_back(8'(8'h20 + i));
        send_frame(fr);
        wait_valid(T35 + 20, got);
        check("ovf_no_valid", 32'(got), 32'd0);
        check("ovf_pulse",    32'(n_ovf - b_ovf), 32'd1);
        check("ovf_no_other", 32'((n_crc - b_crc) + (n_short - b_short)), 32'd0);
        send_frame(fr_a);
        wait_valid(100, got);
        check("ovf_next_valid", 32'(got), 32'd1);
        check("ovf_next_len",   32'(frame_len), 32'd11);
        idle_cycles(T35 + 5);
        ack_frame();
        idle_cycles(3);

        // Reset in the middle of a frame
        b_crc = n_crc;
        b_short = n_short;
        b_ovf = n_ovf;
        for (int i = 0; i < 5; i++) send_byte(fr_a[i]);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mrst_valid", 32'(frame_valid), 32'd0);
        check("mrst_len",   32'(frame_len),   32'd0);
        check("mrst_rden",  32'(rx_rden),     32'd0);
        check("mrst_rdata", 32'(rd_data),     32'd0);
        idle_cycles(2);
        rst_n = 1'b1;
        idle_cycles(T35 + 5);
        check("mrst_no_err", 32'((n_crc - b_crc) + (n_short - b_short) + (n_ovf - b_ovf)), 32'd0);
        send_frame(fr_a);
        wait_valid(100, got);
        check("mrst_next_valid", 32'(got), 32'd1);
        read_chk("mrst_rd0", 4'd0, 8'h01);
        read_chk("mrst_rd9", 4'd9, 8'h67);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
